// File: rtl/axil_gp0_arbiter_if.sv
// Requester command/response channels plus the GP0 AXI4-Lite master port.
// The arbiter connects through the master modport; the requesters and the slave connect through slave.
interface axil_gp0_arbiter_if #(
    parameter int num_req_p    = 2,
    parameter int addr_width_p = 10,
    parameter int data_width_p = 32
) ();
    localparam int strb_width_lp = data_width_p / 8;

    logic [num_req_p-1:0]                req_v_i;
    logic [num_req_p-1:0]                req_w_i;
    logic [num_req_p*addr_width_p-1:0]   req_addr_i;
    logic [num_req_p*data_width_p-1:0]   req_data_i;
    logic [num_req_p*strb_width_lp-1:0]  req_strb_i;
    logic [num_req_p-1:0]                req_ready_o;
    logic [num_req_p-1:0]                resp_v_o;
    logic [data_width_p-1:0]             resp_data_o;
    logic                                resp_err_o;
    logic [num_req_p-1:0]                resp_ready_i;

    logic [addr_width_p-1:0]             m_axi_awaddr;
    logic [2:0]                          m_axi_awprot;
    logic                                m_axi_awvalid;
    logic                                m_axi_awready;
    logic [data_width_p-1:0]             m_axi_wdata;
    logic [strb_width_lp-1:0]            m_axi_wstrb;
    logic                                m_axi_wvalid;
    logic                                m_axi_wready;
    logic [1:0]                          m_axi_bresp;
    logic                                m_axi_bvalid;
    logic                                m_axi_bready;
    logic [addr_width_p-1:0]             m_axi_araddr;
    logic [2:0]                          m_axi_arprot;
    logic                                m_axi_arvalid;
    logic                                m_axi_arready;
    logic [data_width_p-1:0]             m_axi_rdata;
    logic [1:0]                          m_axi_rresp;
    logic                                m_axi_rvalid;
    logic                                m_axi_rready;

    modport master (
        input  req_v_i, req_w_i, req_addr_i, req_data_i, req_strb_i, resp_ready_i,
        output req_ready_o, resp_v_o, resp_data_o, resp_err_o,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output req_v_i, req_w_i, req_addr_i, req_data_i, req_strb_i, resp_ready_i,
        input  req_ready_o, resp_v_o, resp_data_o, resp_err_o,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axil_gp0_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite GP0 slave port among num_req_p requesters,
// one single-word transaction in flight at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request; grant and latch the command
// S_WR    | AW and W outstanding, each dropped after its own handshake
// S_WR_B  | waiting for the write response
// S_RD_AR | AR outstanding
// S_RD_R  | waiting for read data
// S_RESP  | response presented to the granted requester
module axil_gp0_arbiter #(
    parameter int num_req_p    = 2,
    parameter int addr_width_p = 10,
    parameter int data_width_p = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    axil_gp0_arbiter_if.master  bus
);
    localparam int ID_W   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int STRB_W = data_width_p / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD_AR,
        S_RD_R,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [ID_W-1:0]         r_id;
    logic [addr_width_p-1:0] r_addr;
    logic [data_width_p-1:0] r_wdata;
    logic [STRB_W-1:0]       r_strb;
    logic [data_width_p-1:0] r_resp_data;
    logic                    r_err;
    logic                    r_aw_pend;
    logic                    r_w_pend;

    logic                    w_gnt_v;
    logic [ID_W-1:0]         w_gnt_id;
    logic [num_req_p-1:0]    w_req_ready;
    logic [num_req_p-1:0]    w_resp_v;
    logic                    w_unused;

    // First asserted request at or after the round-robin pointer, wrapping modulo num_req_p.
    always_comb begin
        w_gnt_v  = 1'b0;
        w_gnt_id = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (!w_gnt_v && bus.req_v_i[(int'(r_rr_ptr) + k) % num_req_p]) begin
                w_gnt_v  = 1'b1;
                w_gnt_id = ID_W'((int'(r_rr_ptr) + k) % num_req_p);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_resp_v    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_v) begin
                    w_req_ready[w_gnt_id] = 1'b1;
                    w_state_nxt = bus.req_w_i[w_gnt_id] ? S_WR : S_RD_AR;
                end
            end
            S_WR: begin
                if ((!r_aw_pend || bus.m_axi_awready) && (!r_w_pend || bus.m_axi_wready)) begin
                    w_state_nxt = S_WR_B;
                end
            end
            S_WR_B: begin
                if (bus.m_axi_bvalid) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RD_AR: begin
                if (bus.m_axi_arready) begin
                    w_state_nxt = S_RD_R;
                end
            end
            S_RD_R: begin
                if (bus.m_axi_rvalid) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_resp_v[r_id] = 1'b1;
                if (bus.resp_ready_i[r_id]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
            r_aw_pend   <= 1'b0;
            r_w_pend    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_v) begin
                        r_id      <= w_gnt_id;
                        r_addr    <= bus.req_addr_i[w_gnt_id*addr_width_p +: addr_width_p];
                        r_wdata   <= bus.req_data_i[w_gnt_id*data_width_p +: data_width_p];
                        r_strb    <= bus.req_strb_i[w_gnt_id*STRB_W +: STRB_W];
                        r_aw_pend <= bus.req_w_i[w_gnt_id];
                        r_w_pend  <= bus.req_w_i[w_gnt_id];
                        r_rr_ptr  <= (w_gnt_id == ID_W'(num_req_p - 1)) ? '0 : w_gnt_id + 1'b1;
                    end
                end
                S_WR: begin
                    if (bus.m_axi_awready) begin
                        r_aw_pend <= 1'b0;
                    end
                    if (bus.m_axi_wready) begin
                        r_w_pend <= 1'b0;
                    end
                end
                S_WR_B: begin
                    if (bus.m_axi_bvalid) begin
                        r_err       <= bus.m_axi_bresp[1];
                        r_resp_data <= '0;
                    end
                end
                S_RD_R: begin
                    if (bus.m_axi_rvalid) begin
                        r_err       <= bus.m_axi_rresp[1];
                        r_resp_data <= bus.m_axi_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Valids come only from state/flops, so they never follow a ready combinationally.
    assign bus.m_axi_awaddr  = r_addr;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = r_aw_pend;
    assign bus.m_axi_wdata   = r_wdata;
    assign bus.m_axi_wstrb   = r_strb;
    assign bus.m_axi_wvalid  = r_w_pend;
    assign bus.m_axi_bready  = (r_state == S_WR_B);
    assign bus.m_axi_araddr  = r_addr;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = (r_state == S_RD_AR);
    assign bus.m_axi_rready  = (r_state == S_RD_R);

    assign bus.req_ready_o   = w_req_ready;
    assign bus.resp_v_o      = w_resp_v;
    assign bus.resp_data_o   = r_resp_data;
    assign bus.resp_err_o    = r_err;

    // OKAY and EXOKAY are both treated as success, so only bit 1 of a response matters.
    assign w_unused = ^{bus.m_axi_bresp[0], bus.m_axi_rresp[0]};
endmodule

// File: tb/tb_axil_gp0_arbiter.sv
// Directed bench for axil_gp0_arbiter: requester drivers, an AXI-Lite slave model with
// programmable waits, and scoreboard queues checked by monitors on each handshake.
module tb_axil_gp0_arbiter;
    localparam int N = 2;
    localparam int A = 10;
    localparam int D = 32;
    localparam int S = D / 8;

    localparam logic [D-1:0] MEM0 = 32'hA5A5_0000;
    localparam logic [D-1:0] MEM1 = 32'h5A5A_0004;
    localparam logic [D-1:0] MEM2 = 32'h2222_2222;
    localparam logic [D-1:0] MEM3 = 32'h0000_1234;

    typedef struct packed {
        logic [N-1:0] onehot;
        logic [D-1:0] data;
        logic         err;
    } resp_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axil_gp0_arbiter_if #(.num_req_p(N), .addr_width_p(A), .data_width_p(D)) bus ();

    axil_gp0_arbiter #(.num_req_p(N), .addr_width_p(A), .data_width_p(D)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    logic         tb_v    [N];
    logic         tb_w    [N];
    logic [A-1:0] tb_addr [N];
    logic [D-1:0] tb_data [N];
    logic [S-1:0] tb_strb [N];
    logic         tb_rr   [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_v_i[i]            = tb_v[i];
            bus.req_w_i[i]            = tb_w[i];
            bus.req_addr_i[i*A +: A]  = tb_addr[i];
            bus.req_data_i[i*D +: D]  = tb_data[i];
            bus.req_strb_i[i*S +: S]  = tb_strb[i];
            bus.resp_ready_i[i]       = tb_rr[i];
        end
    end

    int checks   = 0;
    int failures = 0;

    resp_t          exp_resp [$];
    logic [A-1:0]   exp_aw   [$];
    logic [A-1:0]   exp_ar   [$];
    logic [D+S-1:0] exp_w    [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout/unexpected required=event", name);
    endtask

    task automatic push_resp(input logic [N-1:0] onehot, input logic [D-1:0] data, input logic err);
        resp_t e;
        e.onehot = onehot;
        e.data   = data;
        e.err    = err;
        exp_resp.push_back(e);
    endtask

    // ---------------- AXI-Lite slave model ----------------
    logic [D-1:0] mem [16];
    int  aw_wait = 0, w_wait = 0, r_wait = 0;
    bit  rd_err = 1'b0;
    int  aw_cnt, w_cnt, r_cnt, b_count;
    bit  aw_fire, w_fire, b_fire, ar_fire, r_fire, got_aw, got_w, r_pend;
    logic [A-1:0] cap_awaddr, cap_araddr;
    logic [D-1:0] cap_wdata;
    logic [S-1:0] cap_wstrb;

    initial begin
        mem[0] = MEM0;
        mem[1] = MEM1;
        mem[2] = MEM2;
        mem[3] = MEM3;
        for (int i = 4; i < 16; i++) mem[i] = '0;
        b_count = 0;
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            aw_cnt = 0; w_cnt = 0; r_cnt = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            got_aw = 0; got_w = 0; r_pend = 0;
            bus.m_axi_awready = 1'b0;
            bus.m_axi_wready  = 1'b0;
            bus.m_axi_bvalid  = 1'b0;
            bus.m_axi_bresp   = 2'b00;
            bus.m_axi_arready = 1'b0;
            bus.m_axi_rvalid  = 1'b0;
            bus.m_axi_rresp   = 2'b00;
            bus.m_axi_rdata   = '0;
        end else begin
            if (aw_fire) got_aw = 1;
            if (w_fire)  got_w  = 1;
            if (b_fire)  bus.m_axi_bvalid = 1'b0;
            if (ar_fire) begin r_pend = 1; r_cnt = 0; end
            if (r_fire)  bus.m_axi_rvalid = 1'b0;
            if (got_aw && got_w && !bus.m_axi_bvalid) begin
                for (int b = 0; b < S; b++)
                    if (cap_wstrb[b]) mem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                bus.m_axi_bvalid = 1'b1;
                bus.m_axi_bresp  = 2'b00;
                got_aw = 0;
                got_w  = 0;
            end
            if (r_pend && !bus.m_axi_rvalid) begin
                if (r_cnt >= r_wait) begin
                    bus.m_axi_rvalid = 1'b1;
                    bus.m_axi_rdata  = mem[cap_araddr[5:2]];
                    bus.m_axi_rresp  = rd_err ? 2'b10 : 2'b00;
                    r_pend = 0;
                end else begin
                    r_cnt++;
                end
            end
            if (bus.m_axi_awvalid && !got_aw) begin
                if (aw_cnt >= aw_wait) bus.m_axi_awready = 1'b1;
                else begin bus.m_axi_awready = 1'b0; aw_cnt++; end
            end else begin
                bus.m_axi_awready = 1'b0;
                aw_cnt = 0;
            end
            if (bus.m_axi_wvalid && !got_w) begin
                if (w_cnt >= w_wait) bus.m_axi_wready = 1'b1;
                else begin bus.m_axi_wready = 1'b0; w_cnt++; end
            end else begin
                bus.m_axi_wready = 1'b0;
                w_cnt = 0;
            end
            bus.m_axi_arready = bus.m_axi_arvalid && !r_pend && !bus.m_axi_rvalid;

            aw_fire = bus.m_axi_awvalid && bus.m_axi_awready;
            w_fire  = bus.m_axi_wvalid && bus.m_axi_wready;
            ar_fire = bus.m_axi_arvalid && bus.m_axi_arready;
            b_fire  = bus.m_axi_bvalid && bus.m_axi_bready;
            r_fire  = bus.m_axi_rvalid && bus.m_axi_rready;

            if (aw_fire) begin
                cap_awaddr = bus.m_axi_awaddr;
                if (exp_aw.size() == 0) fail_now("aw_unexpected");
                else check("aw_addr", 64'(bus.m_axi_awaddr), 64'(exp_aw.pop_front()));
                check("aw_prot", 64'(bus.m_axi_awprot), 64'(0));
            end
            if (w_fire) begin
                cap_wdata = bus.m_axi_wdata;
                cap_wstrb = bus.m_axi_wstrb;
                if (exp_w.size() == 0) fail_now("w_unexpected");
                else check("w_data_strb", 64'({bus.m_axi_wdata, bus.m_axi_wstrb}), 64'(exp_w.pop_front()));
            end
            if (ar_fire) begin
                cap_araddr = bus.m_axi_araddr;
                if (exp_ar.size() == 0) fail_now("ar_unexpected");
                else check("ar_addr", 64'(bus.m_axi_araddr), 64'(exp_ar.pop_front()));
            end
            if (b_fire) b_count++;
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge aclk) begin
        if (aresetn && ((bus.resp_v_o & bus.resp_ready_i) != '0)) begin
            if (exp_resp.size() == 0) begin
                fail_now("resp_unexpected");
            end else begin
                resp_t e;
                e = exp_resp.pop_front();
                check("resp_id",   64'(bus.resp_v_o),    64'(e.onehot));
                check("resp_data", 64'(bus.resp_data_o), 64'(e.data));
                check("resp_err",  64'(bus.resp_err_o),  64'(e.err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge aclk);
        #1;
    endtask

    task automatic issue(input int id, input bit w, input logic [A-1:0] addr,
                         input logic [D-1:0] data, input logic [S-1:0] strb);
        tb_w[id]    = w;
        tb_addr[id] = addr;
        tb_data[id] = data;
        tb_strb[id] = strb;
        tb_v[id]    = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            #1;
            if (bus.req_ready_o[id]) begin
                @(posedge aclk);
                #1;
                tb_v[id] = 1'b0;
                return;
            end
        end
        fail_now("issue_timeout");
        tb_v[id] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_resp.size() == 0 && exp_aw.size() == 0 && exp_w.size() == 0 &&
                exp_ar.size() == 0 && bus.resp_v_o == '0) break;
            @(negedge aclk);
            #2;
        end
        check("drain_pending", 64'(exp_resp.size() + exp_aw.size() + exp_w.size() + exp_ar.size()), 64'(0));
        sync();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            tb_v[i] = 0; tb_w[i] = 0; tb_addr[i] = '0; tb_data[i] = '0; tb_strb[i] = '0; tb_rr[i] = 1;
        end
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        sync();
        check("reset_outputs", 64'({bus.req_ready_o, bus.resp_v_o, bus.m_axi_awvalid, bus.m_axi_wvalid,
                                    bus.m_axi_arvalid, bus.m_axi_bready, bus.m_axi_rready, bus.resp_err_o}), 64'(0));
        check("reset_data", 64'(bus.resp_data_o), 64'(0));

        // Two requesters held valid: grants alternate 0,1,0,1 from rr_ptr=0.
        exp_ar.push_back(10'h000); exp_ar.push_back(10'h004);
        exp_ar.push_back(10'h000); exp_ar.push_back(10'h004);
        push_resp(2'b01, MEM0, 1'b0); push_resp(2'b10, MEM1, 1'b0);
        push_resp(2'b01, MEM0, 1'b0); push_resp(2'b10, MEM1, 1'b0);
        fork
            begin issue(0, 0, 10'h000, '0, '0); issue(0, 0, 10'h000, '0, '0); end
            begin issue(1, 0, 10'h004, '0, '0); issue(1, 0, 10'h004, '0, '0); end
        join
        drain();

        // Zero-wait write, then read it back from the other requester.
        exp_aw.push_back(10'h010);
        exp_w.push_back({32'hDEAD_BEEF, 4'hF});
        push_resp(2'b01, 32'h0, 1'b0);
        issue(0, 1, 10'h010, 32'hDEAD_BEEF, 4'hF);
        drain();
        exp_ar.push_back(10'h010);
        push_resp(2'b10, 32'hDEAD_BEEF, 1'b0);
        issue(1, 0, 10'h010, '0, '0);
        drain();

        // W accepted 3 cycles before AW; partial strobe write read back.
        aw_wait = 3;
        exp_aw.push_back(10'h008);
        exp_w.push_back({32'hCAFE_0001, 4'b0011});
        push_resp(2'b10, 32'h0, 1'b0);
        issue(1, 1, 10'h008, 32'hCAFE_0001, 4'b0011);
        @(negedge aclk); #1;
        check("wr_both_valid", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid}), 64'(2'b11));
        @(negedge aclk); #1;
        check("wr_w_dropped", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid}), 64'(2'b10));
        @(negedge aclk);
        @(negedge aclk); #1;
        check("wr_aw_held", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid}), 64'(2'b10));
        drain();
        aw_wait = 0;
        exp_ar.push_back(10'h008);
        push_resp(2'b01, 32'h2222_0001, 1'b0);
        issue(0, 0, 10'h008, '0, '0);
        drain();

        // SLVERR on read still returns the data.
        rd_err = 1'b1;
        exp_ar.push_back(10'h00C);
        push_resp(2'b01, MEM3, 1'b1);
        issue(0, 0, 10'h00C, '0, '0);
        drain();
        rd_err = 1'b0;

        // Response back-pressure: response held, no grant and no AXI activity meanwhile.
        tb_rr[0] = 1'b0;
        exp_ar.push_back(10'h000);
        push_resp(2'b01, MEM0, 1'b0);
        issue(0, 0, 10'h000, '0, '0);
        begin
            bit seen;
            seen = 0;
            for (int n = 0; n < 50 && !seen; n++) begin
                @(negedge aclk); #1;
                seen = bus.resp_v_o[0];
            end
            if (!seen) fail_now("hold_resp_timeout");
        end
        exp_ar.push_back(10'h004);
        push_resp(2'b10, MEM1, 1'b0);
        fork
            issue(1, 0, 10'h004, '0, '0);
            begin
                for (int n = 0; n < 5; n++) begin
                    check("hold_resp_v",  64'(bus.resp_v_o),    64'(2'b01));
                    check("hold_data",    64'(bus.resp_data_o), 64'(MEM0));
                    check("hold_no_gnt",  64'(bus.req_ready_o), 64'(0));
                    check("hold_no_axi",  64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}), 64'(0));
                    @(negedge aclk); #1;
                end
                sync();
                tb_rr[0] = 1'b1;
            end
        join
        drain();

        // Reset during RD_R abandons the read; afterwards rr_ptr restarts at 0.
        r_wait = 4;
        exp_ar.push_back(10'h004);
        issue(0, 0, 10'h004, '0, '0);
        begin
            bit seen;
            seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge aclk); #1;
                seen = bus.m_axi_rready;
            end
            if (!seen) fail_now("rd_r_timeout");
        end
        aresetn = 1'b0;
        #1;
        check("rst_outputs", 64'({bus.req_ready_o, bus.resp_v_o, bus.m_axi_awvalid, bus.m_axi_wvalid,
                                  bus.m_axi_arvalid, bus.m_axi_bready, bus.m_axi_rready, bus.resp_err_o}), 64'(0));
        check("rst_data", 64'(bus.resp_data_o), 64'(0));
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        r_wait = 0;
        exp_ar.push_back(10'h000); exp_ar.push_back(10'h004);
        push_resp(2'b01, MEM0, 1'b0); push_resp(2'b10, MEM1, 1'b0);
        sync();
        fork
            issue(0, 0, 10'h000, '0, '0);
            issue(1, 0, 10'h004, '0, '0);
        join
        drain();

        check("b_count", 64'(b_count), 64'(2));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule
